// File: rtl/seq_match_det.sv
// rtl/seq_match_det.sv - runtime-programmable byte-stream sequence detector
module seq_match_det #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         cfg_we,
  input  logic [$clog2(MAX_LEN)-1:0]   cfg_idx,
  input  logic [DATA_W-1:0]            cfg_char,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         data_in_valid,
  input  logic                         count_clear,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic                         active
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN+1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   pat  [MAX_LEN];
  logic [DATA_W-1:0]   hist [MAX_LEN-1];
  logic [DATA_W-1:0]   win  [MAX_LEN];
  logic [LW-1:0]       len_r;
  logic                ovl_r;
  logic [IW-1:0]       fill;
  logic                cfg_ok;
  logic                accept;
  logic                flush;
  logic                hit_pat;
  logic                len_ok;
  logic                fill_ok;
  logic                match_now;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus per-cycle strobes: config only in IDLE, characters only in ACTIVE
  always_comb begin
    state_nxt = state;
    cfg_ok    = 1'b0;
    accept    = 1'b0;
    flush     = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ok = cfg_we;
        if (enable) begin
          state_nxt = ST_ACTIVE;
          flush     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        accept = data_in_valid;
        if (!enable) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Candidate window: incoming character followed by history, newest first
  always_comb begin
    win[0] = data_in;
    for (int k = 0; k < MAX_LEN-1; k++) win[k+1] = hist[k];
  end

  // Window position i must equal pattern slot len-1-i for every i below len
  always_comb begin
    int len_i;
    len_i   = int'(len_r);
    hit_pat = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      for (int p = 0; p < MAX_LEN; p++) begin
        if ((i < len_i) && (p == len_i - 1 - i) && (win[i] != pat[p])) hit_pat = 1'b0;
      end
    end
    len_ok    = (len_i >= 1) && (len_i <= MAX_LEN);
    fill_ok   = int'(fill) >= (len_i - 1);
    match_now = accept && len_ok && fill_ok && hit_pat;
  end

  // Pattern, length and mode registers; slots beyond MAX_LEN are never decoded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < MAX_LEN; p++) pat[p] <= '0;
      len_r <= '0;
      ovl_r <= 1'b1;
    end else if (cfg_ok) begin
      for (int p = 0; p < MAX_LEN; p++) begin
        if (cfg_idx == IW'(p)) pat[p] <= cfg_char;
      end
      len_r <= cfg_len;
      ovl_r <= cfg_overlap;
    end
  end

  // History shift register, advanced only by accepted characters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MAX_LEN-1; k++) hist[k] <= '0;
    end else if (accept) begin
      hist[0] <= data_in;
      for (int k = 1; k < MAX_LEN-1; k++) hist[k] <= hist[k-1];
    end
  end

  // Fill counter: how many history entries belong to the current run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill <= '0;
    end else if (flush) begin
      fill <= '0;
    end else if (accept) begin
      if (match_now && !ovl_r)             fill <= '0;
      else if (fill != IW'(MAX_LEN-1))     fill <= fill + IW'(1);
    end
  end

  // Registered match pulse and saturating counter; clear beats increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= match_now;
      if (count_clear)                                        match_count <= '0;
      else if (match_now && (match_count != {CNT_W{1'b1}}))   match_count <= match_count + CNT_W'(1);
    end
  end

  assign active = (state == ST_ACTIVE);

endmodule

// File: tb/tb_seq_match_det.sv
// tb/tb_seq_match_det.sv - scoreboard bench for seq_match_det
module tb_seq_match_det;

  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              cfg_we;
  logic [2:0]        cfg_idx;
  logic [7:0]        cfg_char;
  logic [3:0]        cfg_len;
  logic              cfg_overlap;
  logic [7:0]        data_in;
  logic              data_in_valid;
  logic              count_clear;
  logic              match;
  logic [CNT_W-1:0]  match_count;
  logic              active;

  seq_match_det #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_char(cfg_char), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .data_in(data_in), .data_in_valid(data_in_valid), .count_clear(count_clear),
    .match(match), .match_count(match_count), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit m;
    int cnt;
    bit act;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state: pattern as a string, accepted chars since the last flush
  byte  mpat [MAX_LEN];
  int   mlen;
  bit   movl;
  bit   mact;
  byte  mq[$];
  int   mcnt;

  task automatic model_reset();
    for (int i = 0; i < MAX_LEN; i++) mpat[i] = 0;
    mlen = 0; movl = 1; mact = 0; mcnt = 0;
    mq.delete();
  endtask

  task automatic model_step();
    exp_t e;
    bit m;
    m = 0;
    if (reset) begin
      model_reset();
    end else begin
      if (!mact) begin
        if (cfg_we) begin
          if (int'(cfg_idx) < MAX_LEN) mpat[cfg_idx] = cfg_char;
          mlen = int'(cfg_len);
          movl = cfg_overlap;
        end
        if (enable) begin
          mact = 1;
          mq.delete();
        end
      end else begin
        if (data_in_valid) begin
          mq.push_back(data_in);
          if (mlen >= 1 && mlen <= MAX_LEN && mq.size() >= mlen) begin
            m = 1;
            for (int i = 0; i < mlen; i++)
              if (mq[mq.size() - mlen + i] != mpat[i]) m = 0;
          end
          if (m && !movl) mq.delete();
          while (mq.size() > MAX_LEN) void'(mq.pop_front());
        end
        if (!enable) mact = 0;
      end
      if (count_clear)             mcnt = 0;
      else if (m && mcnt < CNT_MAX) mcnt++;
    end
    e.m = m; e.cnt = mcnt; e.act = mact;
    sb.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic prog(input string s, input int len, input bit ovl);
    enable = 0;
    tick();
    for (int i = 0; i < s.len(); i++) begin
      cfg_we = 1; cfg_idx = 3'(i); cfg_char = s[i]; cfg_len = 4'(len); cfg_overlap = ovl;
      tick();
    end
    cfg_we = 0;
  endtask

  task automatic start();
    enable = 1;
    tick();
  endtask

  task automatic stream(input string s);
    for (int i = 0; i < s.len(); i++) begin
      data_in_valid = 1; data_in = s[i];
      tick();
    end
    data_in_valid = 0;
  endtask

  task automatic gap(input int n);
    data_in_valid = 0;
    repeat (n) tick();
  endtask

  task automatic clear_cnt();
    count_clear = 1;
    tick();
    count_clear = 0;
  endtask

  // monitor: pops one expectation per clock, after the edge has settled
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (match !== e.m) begin
          bad++;
          $display("FAIL match t=%0t got=%b exp=%b", $time, match, e.m);
        end
        total++;
        if (match_count !== CNT_W'(e.cnt)) begin
          bad++;
          $display("FAIL match_count t=%0t got=%0d exp=%0d", $time, match_count, e.cnt);
        end
        total++;
        if (active !== e.act) begin
          bad++;
          $display("FAIL active t=%0t got=%b exp=%b", $time, active, e.act);
        end
      end
    end
  end

  string alpha = "abc";

  initial begin
    int budget;
    reset = 1; enable = 0; cfg_we = 0; cfg_idx = 0; cfg_char = 0; cfg_len = 0;
    cfg_overlap = 0; data_in = 0; data_in_valid = 0; count_clear = 0;
    model_reset();
    @(negedge clk);
    tick(); tick();
    reset = 0;

    prog("hello", 5, 1); start(); stream("hhello"); gap(2);
    clear_cnt();
    stream("hel"); gap(3); stream("lo"); stream("helxlo"); gap(1);

    prog("aba", 3, 1); start(); stream("ababa"); clear_cnt();
    prog("aba", 3, 0); start(); stream("ababa"); clear_cnt();
    prog("aba", 3, 0); start(); stream("abaaba"); clear_cnt();

    prog("abcdefgh", 8, 1); start(); stream("abcdefghabcdefgh"); clear_cnt();
    prog("a", 0, 1); start(); stream("abcdefghabcdefgh"); stream("aaaa"); clear_cnt();

    prog("hello", 5, 1); start();
    stream("hel");
    cfg_we = 1; cfg_idx = 0; cfg_char = "x"; cfg_len = 2; cfg_overlap = 0;
    stream("lo");
    cfg_we = 0;
    stream("hello"); clear_cnt();

    prog("aa", 2, 1); start(); stream("aaaaaa"); gap(1);
    stream("a"); count_clear = 1; stream("a"); count_clear = 0; gap(1);

    prog("hello", 5, 1); start(); stream("hell");
    reset = 1; tick(); tick();
    reset = 0;
    prog("hello", 5, 1); start(); stream("o"); gap(1);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      cfg_we        = ($urandom_range(0, 3) == 0);
      cfg_idx       = 3'($urandom_range(0, 7));
      cfg_char      = alpha[$urandom_range(0, 2)];
      cfg_len       = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
      cfg_overlap   = $urandom_range(0, 1);
      data_in_valid = ($urandom_range(0, 3) != 0);
      data_in       = alpha[$urandom_range(0, 2)];
      count_clear   = ($urandom_range(0, 29) == 0);
      reset         = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0; enable = 0; cfg_we = 0; data_in_valid = 0; count_clear = 0;

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
